// File: rtl/io_uart_responder.sv
`default_nettype none
// ============================================================================
//  Module      : io_uart_responder
//  Description : Memory-mapped IO target (address top nibble 4'h8) with an
//                8N1 UART transmitter/receiver, each holding one byte, and
//                a free-running 32-bit cycle counter. Loads return data one
//                cycle after the strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_uart_responder #(
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int BAUD_RATE  = 115_200
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] io_addr,
   input  logic [3:0]  io_we,
   input  logic        io_re,
   input  logic [31:0] io_wdata,
   output logic [31:0] io_rdata,
   input  logic        serial_in,
   output logic        serial_out
);

   localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
   localparam int TIMER_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(CLKS_PER_BIT - 1);
   localparam logic [TIMER_W-1:0] HALF_LAST =
      TIMER_W'((CLKS_PER_BIT / 2 > 0) ? (CLKS_PER_BIT / 2 - 1) : 0);

   localparam logic [7:0] OFF_TX_STAT = 8'h00;
   localparam logic [7:0] OFF_RX_STAT = 8'h04;
   localparam logic [7:0] OFF_TX_DATA = 8'h08;
   localparam logic [7:0] OFF_RX_DATA = 8'h0C;
   localparam logic [7:0] OFF_COUNT   = 8'h10;

   // ------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------
   logic       sel;
   logic [7:0] offset;
   logic       rd;
   logic       wr;
   logic       tx_write;
   logic       rd_rx_data;
   logic       rd_rx_stat;
   logic       clr_count;
   logic       unused_bits;

   assign sel         = (io_addr[31:28] == 4'h8);
   assign offset      = io_addr[7:0];
   assign rd          = sel & io_re;
   assign wr          = sel & (io_we != 4'b0000);
   assign tx_write    = sel & io_we[0] & (offset == OFF_TX_DATA);
   assign rd_rx_data  = rd & (offset == OFF_RX_DATA);
   assign rd_rx_stat  = rd & (offset == OFF_RX_STAT);
   assign clr_count   = wr & (offset == OFF_COUNT);
   assign unused_bits = ^{io_addr[27:8], io_wdata[31:8]};

   // ------------------------------------------------------------------
   // Transmitter
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

   tx_state_t          tx_state, tx_state_next;
   logic [TIMER_W-1:0] tx_timer;
   logic [7:0]         tx_shift, tx_shift_next;
   logic [2:0]         tx_bit_cnt;
   logic               tx_ready;
   logic               tx_bit_done;

   assign tx_bit_done = (tx_timer == BIT_LAST);

   // TX next state; a write while busy is simply not looked at
   always_comb begin
      tx_state_next = tx_state;
      tx_shift_next = tx_shift;
      case (tx_state)
         TX_IDLE: begin
            if (tx_write) begin
               tx_state_next = TX_START;
               tx_shift_next = io_wdata[7:0];
            end
         end
         TX_START: begin
            if (tx_bit_done) tx_state_next = TX_DATA;
         end
         TX_DATA: begin
            if (tx_bit_done) begin
               tx_shift_next = {1'b0, tx_shift[7:1]};
               if (tx_bit_cnt == 3'd7) tx_state_next = TX_STOP;
            end
         end
         TX_STOP: begin
            if (tx_bit_done) tx_state_next = TX_IDLE;
         end
         default: tx_state_next = TX_IDLE;
      endcase
   end

   // TX registers; the line is registered from the next state so it never glitches
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state   <= TX_IDLE;
         tx_timer   <= '0;
         tx_shift   <= '0;
         tx_bit_cnt <= '0;
         tx_ready   <= 1'b1;
         serial_out <= 1'b1;
      end else begin
         tx_state <= tx_state_next;
         tx_shift <= tx_shift_next;
         if (tx_state == TX_IDLE || tx_bit_done) tx_timer <= '0;
         else                                    tx_timer <= tx_timer + 1'b1;
         if (tx_state != TX_DATA) tx_bit_cnt <= '0;
         else if (tx_bit_done)    tx_bit_cnt <= tx_bit_cnt + 1'b1;
         tx_ready <= (tx_state_next == TX_IDLE);
         case (tx_state_next)
            TX_START: serial_out <= 1'b0;
            TX_DATA:  serial_out <= tx_shift_next[0];
            default:  serial_out <= 1'b1;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Receiver
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   rx_state_t          rx_state, rx_state_next;
   logic [1:0]         rx_sync;
   logic               rx_bit;
   logic               rx_prev;
   logic [TIMER_W-1:0] rx_timer;
   logic [7:0]         rx_shift;
   logic [2:0]         rx_bit_cnt;
   logic               rx_half_done;
   logic               rx_bit_done;
   logic               rx_timer_wrap;
   logic               rx_done;
   logic [7:0]         rx_byte;
   logic               rx_valid;
   logic               overrun;

   assign rx_bit       = rx_sync[1];
   assign rx_half_done = (rx_timer == HALF_LAST);
   assign rx_bit_done  = (rx_timer == BIT_LAST);

   // Two-flop synchroniser plus one delayed copy for falling-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_sync <= 2'b11;
         rx_prev <= 1'b1;
      end else begin
         rx_sync <= {rx_sync[0], serial_in};
         rx_prev <= rx_bit;
      end
   end

   // RX next state; a start needs a falling edge so a line held low after a
   // framing error does not retrigger reception
   always_comb begin
      rx_state_next = rx_state;
      rx_timer_wrap = 1'b0;
      rx_done       = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            rx_timer_wrap = 1'b1;
            if (rx_prev && !rx_bit) rx_state_next = RX_START;
         end
         RX_START: begin
            if (rx_half_done) begin
               rx_timer_wrap = 1'b1;
               rx_state_next = rx_bit ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_bit_done) begin
               rx_timer_wrap = 1'b1;
               if (rx_bit_cnt == 3'd7) rx_state_next = RX_STOP;
            end
         end
         RX_STOP: begin
            if (rx_bit_done) begin
               rx_timer_wrap = 1'b1;
               rx_state_next = RX_IDLE;
               rx_done       = rx_bit;
            end
         end
         default: rx_state_next = RX_IDLE;
      endcase
   end

   // RX state, bit timer and shift register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state   <= RX_IDLE;
         rx_timer   <= '0;
         rx_shift   <= '0;
         rx_bit_cnt <= '0;
      end else begin
         rx_state <= rx_state_next;
         if (rx_timer_wrap) rx_timer <= '0;
         else               rx_timer <= rx_timer + 1'b1;
         if (rx_state == RX_DATA && rx_bit_done) rx_shift <= {rx_bit, rx_shift[7:1]};
         if (rx_state != RX_DATA) rx_bit_cnt <= '0;
         else if (rx_bit_done)    rx_bit_cnt <= rx_bit_cnt + 1'b1;
      end
   end

   // Holding register and status; a data read in the completion cycle
   // consumes the old byte, so it is not an overrun
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_byte  <= '0;
         rx_valid <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         if (rx_done) begin
            rx_byte  <= rx_shift;
            rx_valid <= 1'b1;
         end else if (rd_rx_data) begin
            rx_valid <= 1'b0;
         end
         if (rx_done && rx_valid && !rd_rx_data) overrun <= 1'b1;
         else if (rd_rx_stat)                    overrun <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Cycle counter and load path
   // ------------------------------------------------------------------
   logic [31:0] cycle_count;
   logic [31:0] rd_mux;

   // Free-running counter; a write clears it and wins over the increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         cycle_count <= '0;
      else if (clr_count) cycle_count <= '0;
      else                cycle_count <= cycle_count + 32'd1;
   end

   // Load data select
   always_comb begin
      rd_mux = 32'h0;
      case (offset)
         OFF_TX_STAT: rd_mux = {31'b0, tx_ready};
         OFF_RX_STAT: rd_mux = {30'b0, overrun, rx_valid};
         OFF_RX_DATA: rd_mux = {24'b0, rx_byte};
         OFF_COUNT:   rd_mux = cycle_count;
         default:     rd_mux = 32'h0;
      endcase
   end

   // Load data register, held between strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  io_rdata <= '0;
      else if (rd) io_rdata <= rd_mux;
   end

endmodule
`default_nettype wire

// File: tb/tb_io_uart_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_uart_responder
//  Description : Directed self-checking bench for io_uart_responder
//                (10 clocks per bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_io_uart_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] io_addr = '0;
   logic [3:0]  io_we = '0;
   logic        io_re = 1'b0;
   logic [31:0] io_wdata = '0;
   logic [31:0] io_rdata;
   logic        serial_in = 1'b1;
   logic        serial_out;

   int n_checks = 0;
   int n_pass   = 0;

   io_uart_responder #(
      .CLOCK_FREQ (1000),
      .BAUD_RATE  (100)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .io_addr    (io_addr),
      .io_we      (io_we),
      .io_re      (io_re),
      .io_wdata   (io_wdata),
      .io_rdata   (io_rdata),
      .serial_in  (serial_in),
      .serial_out (serial_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  we;
      logic [31:0] wdata;
      logic        re;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic io_read(input logic [31:0] addr, output logic [31:0] data);
      @(negedge clk);
      io_addr = addr;
      io_re   = 1'b1;
      @(negedge clk);
      io_re   = 1'b0;
      io_addr = '0;
      data    = io_rdata;
   endtask

   task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      io_read(addr, d);
      check(name, d, exp);
   endtask

   task automatic io_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] we);
      @(negedge clk);
      io_addr  = addr;
      io_wdata = data;
      io_we    = we;
      @(negedge clk);
      io_we    = '0;
      io_addr  = '0;
   endtask

   // Start bit, 8 data bits LSB first, chosen stop bit, then line idle
   task automatic send_frame(input logic [7:0] b, input logic stop);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      for (int j = 0; j < 10; j++) begin
         repeat (10) begin
            @(negedge clk);
            serial_in = bits[j];
         end
      end
      @(negedge clk);
      serial_in = 1'b1;
   endtask

   // TX frame of 0xA5 sampled every cycle, with a busy write and status reads
   task automatic tx_frame_test();
      logic [7:0] tx_byte;
      logic       exp_line;
      tx_byte = 8'hA5;
      io_write(32'h8000_0008, 32'h0000_00A5, 4'h1);
      for (int i = 0; i < 120; i++) begin
         if (i < 10)      exp_line = 1'b0;
         else if (i < 90) exp_line = tx_byte[(i / 10) - 1];
         else             exp_line = 1'b1;
         check($sformatf("tx_line[%0d]", i), {31'b0, serial_out}, {31'b0, exp_line});
         if (i == 29) begin
            io_addr = 32'h8000_0008; io_wdata = 32'h0000_003C; io_we = 4'h1;
         end
         if (i == 30) begin
            io_we = 4'h0; io_addr = '0;
         end
         if (i == 49) begin
            io_addr = 32'h8000_0000; io_re = 1'b1;
         end
         if (i == 50) begin
            io_re = 1'b0; io_addr = '0;
            check("tx_ready_busy", io_rdata, 32'h0);
         end
         if (i == 99) begin
            io_addr = 32'h8000_0000; io_re = 1'b1;
         end
         if (i == 100) check("tx_ready_last_busy_cycle", io_rdata, 32'h0);
         if (i == 101) begin
            io_re = 1'b0; io_addr = '0;
            check("tx_ready_restored", io_rdata, 32'h1);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{32'h8000_0000, 4'h0, 32'h0,         1'b1, 32'h1};
      vecs[1]  = '{32'h8000_0004, 4'h0, 32'h0,         1'b1, 32'h0};
      vecs[2]  = '{32'h8000_000C, 4'h0, 32'h0,         1'b1, 32'h0};
      vecs[3]  = '{32'h8000_0024, 4'h0, 32'h0,         1'b1, 32'h0};
      vecs[4]  = '{32'h8000_0000, 4'h0, 32'h0,         1'b1, 32'h1};
      vecs[5]  = '{32'h4000_0004, 4'h0, 32'h0,         1'b1, 32'h1};
      vecs[6]  = '{32'h1000_0008, 4'hF, 32'h0000_0055, 1'b0, 32'h1};
      vecs[7]  = '{32'h8000_0008, 4'h2, 32'h0000_005A, 1'b0, 32'h1};
      vecs[8]  = '{32'h8000_0000, 4'h0, 32'h0,         1'b1, 32'h1};
      vecs[9]  = '{32'h8000_0014, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h1};
      vecs[10] = '{32'h8000_0004, 4'h0, 32'h0,         1'b1, 32'h0};

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_serial_out", {31'b0, serial_out}, 32'h1);
      check("reset_rdata", io_rdata, 32'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Register map vectors; the line must stay idle throughout
      for (int v = 0; v < 11; v++) begin
         @(negedge clk);
         io_addr  = vecs[v].addr;
         io_we    = vecs[v].we;
         io_wdata = vecs[v].wdata;
         io_re    = vecs[v].re;
         @(negedge clk);
         io_addr = '0; io_we = '0; io_re = 1'b0;
         check($sformatf("vec%0d_rdata", v), io_rdata, vecs[v].exp_rdata);
         check($sformatf("vec%0d_line", v), {31'b0, serial_out}, 32'h1);
      end

      // Transmit
      tx_frame_test();

      // Single received byte
      send_frame(8'h3C, 1'b1);
      read_check("rx_status_valid", 32'h8000_0004, 32'h1);
      read_check("rx_data_3c", 32'h8000_000C, 32'h3C);
      read_check("rx_status_cleared", 32'h8000_0004, 32'h0);

      // Overrun
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      read_check("overrun_status", 32'h8000_0004, 32'h3);
      read_check("overrun_data", 32'h8000_000C, 32'h22);
      read_check("overrun_cleared", 32'h8000_0004, 32'h0);

      // Byte completes in the same cycle as a data read
      send_frame(8'h5A, 1'b1);
      fork
         send_frame(8'hC3, 1'b1);
         begin
            repeat (98) @(negedge clk);
            io_addr = 32'h8000_000C; io_re = 1'b1;
            @(negedge clk);
            io_re = 1'b0; io_addr = '0;
            check("same_cycle_old_byte", io_rdata, 32'h5A);
         end
      join
      read_check("same_cycle_status", 32'h8000_0004, 32'h1);
      read_check("same_cycle_new_byte", 32'h8000_000C, 32'hC3);
      read_check("same_cycle_status_after", 32'h8000_0004, 32'h0);

      // Framing error
      send_frame(8'h55, 1'b0);
      repeat (20) @(negedge clk);
      read_check("framing_error_status", 32'h8000_0004, 32'h0);

      // Short low glitch
      @(negedge clk); serial_in = 1'b0;
      repeat (2) @(negedge clk);
      @(negedge clk); serial_in = 1'b1;
      repeat (120) @(negedge clk);
      read_check("glitch_status", 32'h8000_0004, 32'h0);

      // Receiver still works afterwards
      send_frame(8'h96, 1'b1);
      read_check("recover_status", 32'h8000_0004, 32'h1);
      read_check("recover_data", 32'h8000_000C, 32'h96);

      // Cycle counter: clear, then read five counted cycles later
      io_write(32'h8000_0010, 32'h0, 4'h8);
      repeat (4) @(negedge clk);
      read_check("counter_after_clear", 32'h8000_0010, 32'd5);

      // Reset in the middle of a transmission
      io_write(32'h8000_0008, 32'h0000_0000, 4'h1);
      repeat (25) @(negedge clk);
      check("mid_tx_line_low", {31'b0, serial_out}, 32'h0);
      rst_n = 1'b0;
      #1;
      check("reset_mid_tx_line", {31'b0, serial_out}, 32'h1);
      check("reset_mid_tx_rdata", io_rdata, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      read_check("post_reset_tx_ready", 32'h8000_0000, 32'h1);
      repeat (15) @(negedge clk);
      check("post_reset_line_idle", {31'b0, serial_out}, 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
